// File: rtl/data_mem_pkg.sv
// Shared definitions for the load/store data memory: RV32 funct3 size codes
// and the request/response FSM state type.
package data_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_align.sv
// Little-endian lane steering: store byte-enables/lane placement and load
// extraction with sign/zero extension. Misaligned offsets align down.
module data_mem_align
  import data_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [3:0]  byte_en,
  output logic [31:0] wlane,
  output logic [31:0] rdata
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    byte_en  = '0;
    wlane    = '0;
    rdata    = '0;
    sel_byte = word[{offset, 3'b000} +: 8];
    sel_half = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B, F3_BU: begin
        byte_en = 4'b0001 << offset;
        wlane   = {4{wdata[7:0]}};
        rdata   = (funct3 == F3_BU) ? {24'b0, sel_byte}
                                    : {{24{sel_byte[7]}}, sel_byte};
      end
      F3_H, F3_HU: begin
        byte_en = offset[1] ? 4'b1100 : 4'b0011;
        wlane   = {2{wdata[15:0]}};
        rdata   = (funct3 == F3_HU) ? {16'b0, sel_half}
                                    : {{16{sel_half[15]}}, sel_half};
      end
      F3_W: begin
        byte_en = 4'b1111;
        wlane   = wdata;
        rdata   = word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_ls.sv
// Load/store data memory with LATENCY-cycle response and fault reporting.
// Define DATA_MEM_MISALIGN_TRAP_EN to fault misaligned H/W accesses.
module data_mem_ls
  import data_mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [7:0]         mem [DEPTH];

  logic               accept;
  logic               size_ok;
  logic               misaligned;
  logic               req_fault;
  logic [AW-1:0]      base;
  logic [31:0]        rd_word;

  logic               hold_we;
  logic               hold_fault;
  logic [2:0]         hold_funct3;
  logic [1:0]         hold_offset;
  logic [31:0]        hold_word;

  logic [2:0]         lane_funct3;
  logic [1:0]         lane_offset;
  logic [3:0]         byte_en;
  logic [31:0]        wlane;
  logic [31:0]        ld_data;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign base      = req_addr[AW-1:0] & ~AW'(3);

  always_comb begin
    size_ok    = 1'b0;
    misaligned = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W: size_ok = 1'b1;
      F3_BU, F3_HU:     size_ok = !req_we;
      default:          size_ok = 1'b0;
    endcase
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`endif
    req_fault = !size_ok || (req_addr >= 32'(DEPTH)) || misaligned;
  end

  always_comb begin
    rd_word = {mem[base + AW'(3)], mem[base + AW'(2)],
               mem[base + AW'(1)], mem[base]};
  end

  // Lane logic serves the incoming store while idle and the held load otherwise.
  assign lane_funct3 = (state == IDLE) ? req_funct3     : hold_funct3;
  assign lane_offset = (state == IDLE) ? req_addr[1:0]  : hold_offset;

  data_mem_align u_align (
    .funct3  (lane_funct3),
    .offset  (lane_offset),
    .wdata   (req_wdata),
    .word    (hold_word),
    .byte_en (byte_en),
    .wlane   (wlane),
    .rdata   (ld_data)
  );

  // NOTE: the byte array is deliberately left without reset; contents are
  // undefined until written, which keeps it mappable onto RAM.
  always_ff @(posedge clk) begin
    if (accept && req_we && !req_fault) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) mem[base + AW'(k)] <= wlane[8*k +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments throughout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == CNT_W'(1)) state_next = RESP;
        cnt_next = cnt - CNT_W'(1);
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_we     <= 1'b0;
      hold_fault  <= 1'b0;
      hold_funct3 <= '0;
      hold_offset <= '0;
      hold_word   <= '0;
    end else if (accept) begin
      hold_we     <= req_we;
      hold_fault  <= req_fault;
      hold_funct3 <= req_funct3;
      hold_offset <= req_addr[1:0];
      hold_word   <= rd_word;
    end
  end

  assign resp_valid = (state == RESP);
  assign resp_fault = resp_valid && hold_fault;
  assign resp_rdata = (resp_valid && !hold_fault && !hold_we) ? ld_data : '0;

endmodule
